bram_stream_reader: RTL and testbench

- Read-side initiator for a synchronous-read dual-port block RAM port with 1-cycle read latency (address registered in, q valid next cycle, no read enable).
- On a start command it reads `length` consecutive words from `base_addr`, wrapping the address, and emits them on a valid/ready stream.
- It absorbs backpressure with a 2-entry buffer, so the RAM port never needs to stall.
- It sits between a framebuffer or line-buffer RAM (port B) and a video or DMA consumer.

---
 rtl/bram_stream_reader_pkg.sv | 14 +
 rtl/bram_stream_reader_fifo2.sv | 52 +++++
 rtl/bram_stream_reader.sv | 108 ++++++++++
 tb/tb_bram_stream_reader.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_stream_reader_pkg.sv
// Shared types and constants for the BRAM stream reader.
package bram_stream_reader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        FLUSH,
        DONE
    } state_t;

    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/bram_stream_reader_fifo2.sv
// Two-entry first-word-fall-through FIFO; entry0 is always the head.
module bram_stream_reader_fifo2
    import bram_stream_reader_pkg::*;
#(
    parameter int unsigned WIDTH = 9
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head_data
);

    logic [WIDTH-1:0] entry0_q, entry1_q;
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            entry0_q <= '0;
            entry1_q <= '0;
            count_q  <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == '0) entry0_q <= push_data;
                    else               entry1_q <= push_data;
                    count_q <= count_q + CNT_W'(1);
                end
                2'b01: begin
                    entry0_q <= entry1_q;
                    count_q  <= count_q - CNT_W'(1);
                end
                2'b11: begin
                    // Simultaneous push/pop leaves the occupancy unchanged.
                    if (count_q == CNT_W'(1)) begin
                        entry0_q <= push_data;
                    end else begin
                        entry0_q <= entry1_q;
                        entry1_q <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign count     = count_q;
    assign head_data = entry0_q;

endmodule

// File: rtl/bram_stream_reader.sv
// Reads a wrapped run of words from a 1-cycle-latency BRAM port onto a valid/ready stream.
module bram_stream_reader
    import bram_stream_reader_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wren,
    output logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] mem_q,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    localparam logic [ADDR_W:0] ONE = (ADDR_W + 1)'(1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   remaining_q, remaining_d;
    logic              inflight_q, inflight_d;
    logic              inflight_last_q, inflight_last_d;

    logic [CNT_W-1:0]  fifo_count;
    logic [DATA_W:0]   head_data;
    logic [CNT_W:0]    occupancy, limit;
    logic              pop, issue;

    assign pop = out_valid && out_ready;

    // Words buffered plus the one in flight must leave room for the word being issued.
    assign occupancy = (CNT_W + 1)'(fifo_count) + (CNT_W + 1)'(inflight_q);
    assign limit     = (CNT_W + 1)'(FIFO_DEPTH) + (CNT_W + 1)'(pop);
    assign issue     = (state_q == READ) && (remaining_q != '0) && (occupancy < limit);

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        remaining_d     = remaining_q;
        inflight_d      = issue;
        inflight_last_d = issue && (remaining_q == ONE);
        if (issue) begin
            addr_d      = addr_q + ADDR_W'(1);
            remaining_d = remaining_q - ONE;
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d      = base_addr;
                    remaining_d = length;
                    state_d     = (length != '0) ? READ : DONE;
                end
            end
            READ:    if (issue && (remaining_q == ONE)) state_d = FLUSH;
            FLUSH:   if (pop && out_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            remaining_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            remaining_q     <= remaining_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
        end
    end

    bram_stream_reader_fifo2 #(
        .WIDTH (DATA_W + 1)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (inflight_q),
        .push_data ({inflight_last_q, mem_q}),
        .pop       (pop),
        .count     (fifo_count),
        .head_data (head_data)
    );

    assign out_valid = (fifo_count != '0);
    assign out_data  = head_data[DATA_W-1:0];
    assign out_last  = out_valid && head_data[DATA_W];

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign mem_addr = addr_q;
    assign mem_wren = 1'b0;
    assign mem_data = '0;

endmodule

// File: tb/tb_bram_stream_reader.sv
// Randomised bench for bram_stream_reader against a queue-based word model.
module tb_bram_stream_reader;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clock, reset, start, busy, done, mem_wren, out_valid, out_ready, out_last;
    logic [ADDR_W-1:0] base_addr, mem_addr;
    logic [ADDR_W:0]   length;
    logic [DATA_W-1:0] mem_data, mem_q, out_data;

    bram_stream_reader #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_wren  (mem_wren),
        .mem_data  (mem_data),
        .mem_q     (mem_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [DATA_W-1:0] ram [DEPTH];
    initial for (int i = 0; i < DEPTH; i++) ram[i] = 8'(i);
    always @(posedge clock) mem_q <= ram[mem_addr];

    int total = 0;
    int bad   = 0;

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: every accepted command queues its words up front.
    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } word_t;

    word_t             exp_q[$];
    logic              busy_m = 1'b0, done_m = 1'b0, stall_prev = 1'b0;
    logic [DATA_W-1:0] prev_data = '0, last_pop_data = '0;
    int                pops_total = 0;

    always @(negedge clock) begin
        logic accept, pop, done_next, busy_next;
        word_t w;
        if (reset) begin
            exp_q.delete();
            busy_m     = 1'b0;
            done_m     = 1'b0;
            stall_prev = 1'b0;
        end else begin
            chk(busy === busy_m, "busy", int'(busy), int'(busy_m));
            chk(done === done_m, "done", int'(done), int'(done_m));
            if (exp_q.size() == 0) begin
                chk(out_valid === 1'b0, "no_word_valid", int'(out_valid), 0);
            end else if (out_valid) begin
                chk(out_data === exp_q[0].data, "data", int'(out_data), int'(exp_q[0].data));
                chk(out_last === exp_q[0].last, "last", int'(out_last), int'(exp_q[0].last));
            end
            if (stall_prev) begin
                chk(out_valid === 1'b1, "hold_valid", int'(out_valid), 1);
                chk(out_data === prev_data, "hold_data", int'(out_data), int'(prev_data));
            end
            accept    = start && !busy_m;
            pop       = out_valid && out_ready && (exp_q.size() != 0);
            done_next = 1'b0;
            if (pop) begin
                pops_total++;
                last_pop_data = out_data;
                done_next     = exp_q[0].last;
                void'(exp_q.pop_front());
            end
            if (accept) begin
                if (length == 0) done_next = 1'b1;
                for (int k = 0; k < int'(length); k++) begin
                    w.data = ram[(int'(base_addr) + k) % DEPTH];
                    w.last = (k == int'(length) - 1);
                    exp_q.push_back(w);
                end
            end
            busy_next  = accept ? 1'b1 : (done_m ? 1'b0 : busy_m);
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
            busy_m     = busy_next;
            done_m     = done_next;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic launch(input int b, input int len);
        start     = 1'b1;
        base_addr = ADDR_W'(b);
        length    = (ADDR_W + 1)'(len);
        step();
        start = 1'b0;
    endtask

    initial begin
        int  p0;
        bit  seen;
        logic [DATA_W-1:0] want;

        reset = 1'b1; start = 1'b0; base_addr = '0; length = '0; out_ready = 1'b1;
        repeat (3) step();
        chk(busy === 1'b0 && done === 1'b0, "rst_busy_done", int'({busy, done}), 0);
        chk(out_valid === 1'b0 && out_last === 1'b0, "rst_valid_last",
            int'({out_valid, out_last}), 0);
        chk(out_data === '0 && mem_addr === '0, "rst_data_addr", int'(mem_addr), 0);
        chk(mem_wren === 1'b0 && mem_data === '0, "tied_write", int'(mem_wren), 0);
        reset = 1'b0;
        repeat (2) step();

        // Basic 4-word read with latency pinned.
        launch(5, 4);
        chk(out_valid === 1'b0, "t1_valid_e0", int'(out_valid), 0);
        step();
        chk(out_valid === 1'b0, "t1_valid_e1", int'(out_valid), 0);
        step();
        chk(out_valid === 1'b1, "t1_valid_e2", int'(out_valid), 1);
        for (int i = 0; i < 4; i++) begin
            want = 8'(5 + i);
            chk(out_data === want, "t1_word", int'(out_data), int'(want));
            chk(out_last === (i == 3), "t1_last", int'(out_last), int'(i == 3));
            step();
        end
        chk(done === 1'b1, "t1_done", int'(done), 1);
        step();
        chk(done === 1'b0 && busy === 1'b0, "t1_idle", int'({busy, done}), 0);

        // Address wrap.
        launch('h3FE, 4);
        chk(mem_addr === 10'h3FE, "t2_addr0", int'(mem_addr), 'h3FE);
        step();
        chk(mem_addr === 10'h3FF, "t2_addr1", int'(mem_addr), 'h3FF);
        step();
        chk(mem_addr === 10'h000, "t2_addr2", int'(mem_addr), 0);
        chk(out_data === 8'hFE, "t2_word0", int'(out_data), 'hFE);
        step();
        chk(mem_addr === 10'h001, "t2_addr3", int'(mem_addr), 1);
        chk(out_data === 8'hFF, "t2_word1", int'(out_data), 'hFF);
        step();
        chk(out_data === 8'h00, "t2_word2", int'(out_data), 0);
        step();
        chk(out_data === 8'h01 && out_last === 1'b1, "t2_word3", int'(out_data), 1);
        repeat (3) step();

        // Zero-length command.
        launch('h123, 0);
        chk(busy === 1'b1 && done === 1'b1 && out_valid === 1'b0, "t3_done",
            int'({busy, done, out_valid}), 'b110);
        step();
        chk(busy === 1'b0 && done === 1'b0, "t3_idle", int'({busy, done}), 0);
        repeat (2) step();

        // Random backpressure with a forced 5-cycle stall.
        p0 = pops_total;
        launch('h010, 16);
        seen = 1'b0;
        for (int c = 0; c < 500 && !seen; c++) begin
            out_ready = (c >= 4 && c < 9) ? 1'b0 : 1'(($urandom_range(0, 3) != 0) ? 1 : 0);
            step();
            if (done) seen = 1'b1;
        end
        out_ready = 1'b1;
        chk(seen, "t4_done_seen", int'(seen), 1);
        chk(pops_total - p0 == 16, "t4_word_count", pops_total - p0, 16);
        repeat (2) step();

        // Full-depth read with ignored start pulses.
        p0 = pops_total;
        launch('h200, DEPTH);
        seen = 1'b0;
        for (int c = 0; c < 1200 && !seen; c++) begin
            start     = (c % 100 == 50);
            base_addr = ADDR_W'($urandom);
            length    = (ADDR_W + 1)'(3);
            step();
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        chk(seen, "t5_done_seen", int'(seen), 1);
        chk(pops_total - p0 == DEPTH, "t5_word_count", pops_total - p0, DEPTH);
        chk(last_pop_data === 8'hFF, "t5_last_word", int'(last_pop_data), 'hFF);
        repeat (3) step();

        // Reset in the middle of a command.
        p0 = pops_total;
        launch('h040, 8);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (pops_total - p0 >= 2) seen = 1'b1;
            else step();
        end
        chk(seen, "t6_reach_word3", pops_total - p0, 2);
        #2 reset = 1'b1;
        #1;
        chk(busy === 1'b0 && out_valid === 1'b0 && done === 1'b0, "t6_reset_now",
            int'({busy, out_valid, done}), 0);
        step();
        reset = 1'b0;
        step();
        chk(done === 1'b0 && out_valid === 1'b0, "t6_no_done", int'({done, out_valid}), 0);
        launch('h020, 2);
        step();
        step();
        chk(out_data === 8'h20 && out_last === 1'b0, "t6_word0", int'(out_data), 'h20);
        step();
        chk(out_data === 8'h21 && out_last === 1'b1, "t6_word1", int'(out_data), 'h21);
        step();
        chk(done === 1'b1, "t6_done", int'(done), 1);
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
